// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared types and defaults for the main-memory bus arbiter.
//   state_t : arbiter sequencer states (IDLE -> ACCESS -> RESP -> IDLE)
//   op_t    : transaction type latched at grant time (OP_RD / OP_WR)
//   DEF_*   : default requester count and memory widths
// -----------------------------------------------------------------------------
package mem_bus_pkg;

    localparam int DEF_NREQ   = 4;
    localparam int DEF_AWIDTH = 9;
    localparam int DEF_DWIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin winner selection with a registered last-grant pointer.
//   clk, reset : clock, asynchronous active-high reset
//   i_req      : request vector (one bit per requester)
//   i_en       : load the pointer with the current winner
//   o_grant    : combinational one-hot winner (zero when no request)
//   o_any      : at least one request present
// The search begins at pointer+1 and wraps, so the most recent winner has the
// lowest priority. The pointer resets to NREQ-1, giving requester 0 first pick.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_en,
    output logic [NREQ-1:0] o_grant,
    output logic            o_any
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_win_idx;
    logic [NREQ-1:0] w_grant;
    logic            w_found;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_grant   = '0;
        w_found   = 1'b0;
        w_win_idx = r_ptr;
        w_idx     = '0;
        for (int off = 1; off <= NREQ; off++) begin
            // Modulo handles NREQ values that are not a power of two.
            w_idx = IW'((int'(r_ptr) + off) % NREQ);
            if (!w_found && i_req[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_win_idx      = w_idx;
                w_found        = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= IW'(NREQ - 1);
        end else if (i_en) begin
            r_ptr <= w_win_idx;
        end
    end

    assign o_grant = w_grant;
    assign o_any   = w_found;

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares a single-port main memory among NREQ cache controllers. One
// transaction at a time: IDLE (arbitrate) -> ACCESS (one-cycle strobe) ->
// RESP (one-cycle ack, read data) -> IDLE.
//   clk, reset           : clock, asynchronous active-high reset
//   req_rd / req_wr      : per-requester level requests, held until ack
//   req_addr / req_wdata : packed per-requester address / write data
//   req_ack / req_rdata  : one-cycle ack to the serviced requester, read data
//   grant / busy         : one-hot owner (ACCESS, RESP), sequencer busy
//   rd_mem / wr_mem      : memory strobes, high for the ACCESS cycle only
//   addr_mem / mem_wdata : memory address / write data
//   mem_rdata / ready_mem: memory read data / memory idle indication
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_rd,
    input  logic [NREQ-1:0]        req_wr,
    input  logic [NREQ*AWIDTH-1:0] req_addr,
    input  logic [NREQ*DWIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ack,
    output logic [DWIDTH-1:0]      req_rdata,
    output logic [NREQ-1:0]        grant,
    output logic                   busy,
    output logic                   rd_mem,
    output logic                   wr_mem,
    output logic [AWIDTH-1:0]      addr_mem,
    output logic [DWIDTH-1:0]      mem_wdata,
    input  logic [DWIDTH-1:0]      mem_rdata,
    input  logic                   ready_mem
);

    state_t              r_state;
    op_t                 r_op;
    logic [NREQ-1:0]     r_grant;
    logic [NREQ-1:0]     r_ack;
    logic [DWIDTH-1:0]   r_rdata;
    logic                r_busy;
    logic                r_rd_mem;
    logic                r_wr_mem;
    logic [AWIDTH-1:0]   r_addr;
    logic [DWIDTH-1:0]   r_wdata;

    logic [NREQ-1:0]     w_win;
    logic                w_any;
    logic                w_start;
    logic [AWIDTH-1:0]   w_sel_addr;
    logic [DWIDTH-1:0]   w_sel_wdata;
    op_t                 w_sel_op;

    // A transaction may only start from IDLE while the memory reports idle.
    assign w_start = (r_state == IDLE) && ready_mem && w_any;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .i_req   (req_rd | req_wr),
        .i_en    (w_start),
        .o_grant (w_win),
        .o_any   (w_any)
    );

    // Route the winner's address/data; a write request takes precedence over
    // a simultaneous read from the same requester.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_op    = OP_RD;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win[i]) begin
                w_sel_addr  = req_addr[i*AWIDTH +: AWIDTH];
                w_sel_wdata = req_wdata[i*DWIDTH +: DWIDTH];
                if (req_wr[i]) w_sel_op = OP_WR;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_op     <= OP_RD;
            r_grant  <= '0;
            r_ack    <= '0;
            r_rdata  <= '0;
            r_busy   <= 1'b0;
            r_rd_mem <= 1'b0;
            r_wr_mem <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_grant  <= w_win;
                        r_addr   <= w_sel_addr;
                        r_wdata  <= w_sel_wdata;
                        r_op     <= w_sel_op;
                        r_rd_mem <= (w_sel_op == OP_RD);
                        r_wr_mem <= (w_sel_op == OP_WR);
                        r_busy   <= 1'b1;
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_rd_mem <= 1'b0;
                    r_wr_mem <= 1'b0;
                    // Memory read data settles during ACCESS; capture it here
                    // so it is presented alongside the ack. Writes keep the
                    // previous read value.
                    if (r_op == OP_RD) r_rdata <= mem_rdata;
                    r_ack    <= r_grant;
                    r_state  <= RESP;
                end
                RESP: begin
                    r_ack   <= '0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ack   = r_ack;
    assign req_rdata = r_rdata;
    assign grant     = r_grant;
    assign busy      = r_busy;
    assign rd_mem    = r_rd_mem;
    assign wr_mem    = r_wr_mem;
    assign addr_mem  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter with a falling-edge main-memory model.
// Outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 9;
    localparam int DW   = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_rd;
    logic [NREQ-1:0]    req_wr;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ack;
    logic [DW-1:0]      req_rdata;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic               rd_mem;
    logic               wr_mem;
    logic [AW-1:0]      addr_mem;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
    logic               ready_mem;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .req_rdata (req_rdata),
        .grant     (grant),
        .busy      (busy),
        .rd_mem    (rd_mem),
        .wr_mem    (wr_mem),
        .addr_mem  (addr_mem),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .ready_mem (ready_mem)
    );

    // Main memory: latches address and write data on the falling edge.
    always @(negedge clk) begin
        if (wr_mem) mem[addr_mem] <= mem_wdata;
        if (rd_mem) mem_rdata <= mem[addr_mem];
    end

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 9'h005) ? 32'hDEADBEEF : (32'h1000_0000 | 32'(a));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({rd_mem, wr_mem, busy, grant, req_ack} !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b expected 0", {rd_mem, wr_mem, busy, grant, req_ack});
        end
        n_cmp++;
        if ({addr_mem, mem_wdata, req_rdata} !== 73'b0) begin
            n_bad++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h expected 0", addr_mem, mem_wdata, req_rdata);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // All four hold reads; each drops only for the cycle after its ack.
    task automatic test_fairness();
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};
        int drop [NREQ];
        int n_ack = 0;
        int who;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, AW'(9'h010 + i), '0);
            drop[i] = 0;
        end
        req_rd = '1;
        for (int cyc = 0; cyc < 60 && n_ack < 6; cyc++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (drop[i] > 0) begin
                    drop[i]--;
                    if (drop[i] == 0) req_rd[i] = 1'b1;
                end
            end
            if (req_ack != '0) begin
                who = -1;
                for (int i = 0; i < NREQ; i++) if (req_ack[i]) who = i;
                n_cmp++;
                if (who != exp_order[n_ack]) begin
                    n_bad++;
                    $display("FAIL fair_order[%0d]: got req %0d ack=%b expected req %0d", n_ack, who, req_ack, exp_order[n_ack]);
                end
                n_cmp++;
                if (req_rdata !== init_val(AW'(9'h010 + exp_order[n_ack]))) begin
                    n_bad++;
                    $display("FAIL fair_rdata[%0d]: got %h expected %h", n_ack, req_rdata, init_val(AW'(9'h010 + exp_order[n_ack])));
                end
                if (who >= 0) begin
                    req_rd[who] = 1'b0;
                    drop[who]   = 2;
                end
                n_ack++;
            end
        end
        n_cmp++;
        if (n_ack != 6) begin
            n_bad++;
            $display("FAIL fair_timeout: got %0d acks expected 6", n_ack);
        end
        req_rd = '0;
        tick();
        tick();
    endtask

    task automatic test_single_read();
        set_req(0, 9'h005, '0);
        req_rd[0] = 1'b1;
        tick();
        n_cmp++;
        if ({rd_mem, wr_mem, busy, grant, req_ack, addr_mem} !== {3'b101, 4'b0001, 4'b0000, 9'h005}) begin
            n_bad++;
            $display("FAIL sr_access: rd=%b wr=%b busy=%b grant=%b ack=%b addr=%h expected rd=1 grant=0001 addr=005",
                     rd_mem, wr_mem, busy, grant, req_ack, addr_mem);
        end
        tick();
        n_cmp++;
        if ({rd_mem, wr_mem, busy, req_ack} !== {3'b001, 4'b0001}) begin
            n_bad++;
            $display("FAIL sr_resp: rd=%b wr=%b busy=%b ack=%b expected ack=0001 busy=1", rd_mem, wr_mem, busy, req_ack);
        end
        n_cmp++;
        if (req_rdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL sr_rdata: got %h expected deadbeef", req_rdata);
        end
        req_rd[0] = 1'b0;
        tick();
        n_cmp++;
        if ({busy, grant, req_ack} !== 9'b0) begin
            n_bad++;
            $display("FAIL sr_idle: busy=%b grant=%b ack=%b expected 0", busy, grant, req_ack);
        end
    endtask

    task automatic test_write_read();
        set_req(2, 9'h1FF, 32'h12345678);
        req_wr[2] = 1'b1;
        tick();
        n_cmp++;
        if ({rd_mem, wr_mem, grant, addr_mem, mem_wdata} !== {2'b01, 4'b0100, 9'h1FF, 32'h12345678}) begin
            n_bad++;
            $display("FAIL wr_access: rd=%b wr=%b grant=%b addr=%h wdata=%h expected wr=1 grant=0100 addr=1ff wdata=12345678",
                     rd_mem, wr_mem, grant, addr_mem, mem_wdata);
        end
        tick();
        n_cmp++;
        if ({wr_mem, req_ack, req_rdata} !== {1'b0, 4'b0100, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL wr_resp: wr=%b ack=%b rdata=%h expected wr=0 ack=0100 rdata=deadbeef", wr_mem, req_ack, req_rdata);
        end
        req_wr[2] = 1'b0;
        tick();
        req_rd[2] = 1'b1;
        tick();
        n_cmp++;
        if ({rd_mem, wr_mem, addr_mem} !== {2'b10, 9'h1FF}) begin
            n_bad++;
            $display("FAIL rb_access: rd=%b wr=%b addr=%h expected rd=1 addr=1ff", rd_mem, wr_mem, addr_mem);
        end
        tick();
        n_cmp++;
        if ({req_ack, req_rdata} !== {4'b0100, 32'h12345678}) begin
            n_bad++;
            $display("FAIL rb_resp: ack=%b rdata=%h expected ack=0100 rdata=12345678", req_ack, req_rdata);
        end
        req_rd[2] = 1'b0;
        tick();
    endtask

    task automatic test_rd_wr_same();
        set_req(1, 9'h0A0, 32'hCAFEF00D);
        req_rd[1] = 1'b1;
        req_wr[1] = 1'b1;
        tick();
        n_cmp++;
        if ({rd_mem, wr_mem, grant, addr_mem} !== {2'b01, 4'b0010, 9'h0A0}) begin
            n_bad++;
            $display("FAIL rw_access: rd=%b wr=%b grant=%b addr=%h expected wr only grant=0010 addr=0a0",
                     rd_mem, wr_mem, grant, addr_mem);
        end
        tick();
        n_cmp++;
        if (req_ack !== 4'b0010) begin
            n_bad++;
            $display("FAIL rw_ack: got %b expected 0010", req_ack);
        end
        req_wr[1] = 1'b0;
        tick();
        n_cmp++;
        if ({req_ack, busy, rd_mem, wr_mem} !== 7'b0) begin
            n_bad++;
            $display("FAIL rw_single_ack: ack=%b busy=%b rd=%b wr=%b expected 0", req_ack, busy, rd_mem, wr_mem);
        end
        tick();
        n_cmp++;
        if ({rd_mem, wr_mem, grant} !== {2'b10, 4'b0010}) begin
            n_bad++;
            $display("FAIL rw_read_access: rd=%b wr=%b grant=%b expected rd=1 grant=0010", rd_mem, wr_mem, grant);
        end
        tick();
        n_cmp++;
        if ({req_ack, req_rdata} !== {4'b0010, 32'hCAFEF00D}) begin
            n_bad++;
            $display("FAIL rw_read_resp: ack=%b rdata=%h expected ack=0010 rdata=cafef00d", req_ack, req_rdata);
        end
        req_rd[1] = 1'b0;
        tick();
    endtask

    task automatic test_ready_low();
        ready_mem = 1'b0;
        set_req(3, 9'h033, '0);
        req_rd[3] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({grant, rd_mem, wr_mem, busy} !== 7'b0) begin
                n_bad++;
                $display("FAIL nr_hold[%0d]: grant=%b rd=%b wr=%b busy=%b expected 0", c, grant, rd_mem, wr_mem, busy);
            end
        end
        ready_mem = 1'b1;
        tick();
        n_cmp++;
        if ({rd_mem, grant, addr_mem} !== {1'b1, 4'b1000, 9'h033}) begin
            n_bad++;
            $display("FAIL nr_release: rd=%b grant=%b addr=%h expected rd=1 grant=1000 addr=033", rd_mem, grant, addr_mem);
        end
        tick();
        n_cmp++;
        if ({req_ack, req_rdata} !== {4'b1000, init_val(9'h033)}) begin
            n_bad++;
            $display("FAIL nr_resp: ack=%b rdata=%h expected ack=1000 rdata=%h", req_ack, req_rdata, init_val(9'h033));
        end
        req_rd[3] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        // Requester 0 alone moves the pointer to 0.
        set_req(0, 9'h040, '0);
        set_req(1, 9'h041, '0);
        set_req(2, 9'h042, '0);
        req_rd[0] = 1'b1;
        tick();
        tick();
        req_rd[0] = 1'b0;
        tick();
        // Pointer 0: requester 1 wins ahead of 0 and 2.
        req_rd[2:0] = 3'b111;
        tick();
        n_cmp++;
        if ({rd_mem, grant} !== {1'b1, 4'b0010}) begin
            n_bad++;
            $display("FAIL rm_pre: rd=%b grant=%b expected rd=1 grant=0010", rd_mem, grant);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({rd_mem, grant, busy} !== 6'b0) begin
            n_bad++;
            $display("FAIL rm_async_clear: rd=%b grant=%b busy=%b expected 0", rd_mem, grant, busy);
        end
        tick();
        n_cmp++;
        if ({req_ack, req_rdata} !== 36'b0) begin
            n_bad++;
            $display("FAIL rm_no_ack: ack=%b rdata=%h expected 0", req_ack, req_rdata);
        end
        reset = 1'b0;
        tick();
        // Pointer back to NREQ-1: requester 0 has priority again.
        n_cmp++;
        if ({rd_mem, grant, addr_mem} !== {1'b1, 4'b0001, 9'h040}) begin
            n_bad++;
            $display("FAIL rm_restart: rd=%b grant=%b addr=%h expected rd=1 grant=0001 addr=040", rd_mem, grant, addr_mem);
        end
        tick();
        n_cmp++;
        if ({req_ack, req_rdata} !== {4'b0001, init_val(9'h040)}) begin
            n_bad++;
            $display("FAIL rm_resp: ack=%b rdata=%h expected ack=0001 rdata=%h", req_ack, req_rdata, init_val(9'h040));
        end
        req_rd = '0;
        tick();
        tick();
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = init_val(AW'(a));
        req_rd    = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        ready_mem = 1'b1;
        test_reset();
        test_fairness();
        test_single_read();
        test_write_read();
        test_rd_wr_same();
        test_ready_low();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter and sequencer that shares the single-port main memory among NREQ requesters (cache controllers on the MSI bus). It accepts per-requester read/write requests, grants one at a time, drives the memory's rd_mem/wr_mem/addr_mem/data_in strobes for exactly one cycle per transaction, and returns read data with a one-cycle acknowledge. It sits between the cache controllers and main_memory.

## Interface
- NREQ, 4, number of requesters (2..8)
- AWIDTH, 9, memory address width
- DWIDTH, 32, memory data width
- clk  input  1  single clock; all state on rising edge (memory samples on falling edge)
- reset  input  1  asynchronous, active-high reset
- req_rd  input  NREQ  per-requester read request, level, held until ack
- req_wr  input  NREQ  per-requester write request, level, held until ack
- req_addr  input  NREQ*AWIDTH  requester i address at bits [i*AWIDTH +: AWIDTH]
- req_wdata  input  NREQ*DWIDTH  requester i write data at [i*DWIDTH +: DWIDTH]
- req_ack  output  NREQ  one-cycle pulse to the serviced requester
- req_rdata  output  DWIDTH  read data, valid while req_ack is high
- grant  output  NREQ  one-hot current owner, zero when idle
- busy  output  1  high in ACCESS and RESP
- rd_mem  output  1  memory read strobe
- wr_mem  output  1  memory write strobe
- addr_mem  output  AWIDTH  memory address
- mem_wdata  output  DWIDTH  to memory data_in
- mem_rdata  input  DWIDTH  from memory data_out
- ready_mem  input  1  memory idle indication

## Operation
- States: IDLE, ACCESS, RESP. Reset → IDLE.
- IDLE: if ready_mem=1 and any req_rd|req_wr bit set, pick winner by round-robin, register grant, addr_mem, mem_wdata, op type; go ACCESS. With ready_mem=0, stay IDLE and grant nothing.
- ACCESS: exactly one of rd_mem/wr_mem high for one cycle; go RESP unconditionally.
- RESP: strobes low; req_ack[winner]=1; for reads req_rdata = mem_rdata captured at end of ACCESS, for writes req_rdata holds its previous value. Go IDLE.
- Round-robin: last-grant pointer, reset to NREQ-1, so requester 0 has first priority. Search starts at pointer+1 modulo NREQ and wraps. Pointer updates to winner on entering ACCESS.
- A requester with both req_rd and req_wr set is serviced as a write. The ack covers the write only. If req_rd is still high after the ack, it is a new request and competes normally.
- Requests are sampled only in IDLE. Changes to another requester's inputs during ACCESS/RESP have no effect.
- All outputs are registered. Reset values: rd_mem=0, wr_mem=0, addr_mem=0, mem_wdata=0, req_ack=0, req_rdata=0, grant=0, busy=0.
- Reset asserted mid-transaction clears all outputs immediately (asynchronous). The in-flight transaction is dropped without an ack. A write whose strobe saw a falling edge may already be committed in memory.

## Timing
- Cycle N (IDLE): request seen, winner chosen.
- Cycle N+1 (ACCESS): strobe high. Memory latches address and write at the falling edge of N+1. Read data settles before the rising edge ending N+1.
- Cycle N+2 (RESP): req_ack and req_rdata valid.
- Cycle N+3: IDLE, next arbitration.
- Latency from request to ack: 2 cycles. Peak throughput: 1 transaction per 3 cycles.
- A requester must drop its request in the cycle after its ack (N+3). If it is still high at N+3, that is a new transaction.
- A write followed by a read of the same address returns the new data.

## Structure
- Shared package mem_bus_pkg: state enum (IDLE/ACCESS/RESP), op-type constant (OP_RD/OP_WR), default widths.
- Sub-module rr_arbiter (parameter NREQ): combinational one-hot winner from request vector and pointer, plus the registered pointer with enable. The FSM and datapath muxing stay in mem_bus_arbiter.

## Test plan
- Single read: requester 0 reads addr 0x005 (memory preloaded 0xDEADBEEF) → rd_mem high exactly cycle N+1 with addr_mem=0x005; req_ack[0] and req_rdata=0xDEADBEEF at N+2.
- Write then read: requester 2 writes 0x12345678 to 0x1FF, then reads 0x1FF → wr_mem one cycle, ack at N+2; the read returns 0x12345678.
- Fairness: all 4 requesters hold reads continuously, each dropping its request only for the cycle after its ack → grant order 0,1,2,3,0,1 with no requester skipped or served twice consecutively.
- Simultaneous rd and wr from requester 1 → write performed and a single ack; held req_rd is then serviced as a separate read returning the written value.
- ready_mem forced low with pending requests → grant stays 0 and no strobes; release ready_mem → transaction starts next cycle.
- Reset asserted during ACCESS of a read → rd_mem, grant and busy go 0 immediately with no ack; after release, the held request is serviced from IDLE with requester 0 priority restored.
